cpu_divider_ctrl: RTL and testbench

//   Sequential radix-2 restoring divider with its own control FSM. Feeds the

---
 rtl/cpu_divider_ctrl.sv | 117 +++++++++++
 tb/tb_cpu_divider_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_divider_ctrl.sv
// Sequential radix-2 restoring divider with control FSM.
// A single run yields both quotient and remainder for DIV and MOD ops.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | one shift/subtract step per cycle, WIDTH cycles
// FIXUP | apply result signs for signed operations
// DONE  | results valid and held; start launches the next op
module cpu_divider_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_rem;
  logic [WIDTH-1:0] acc_quo;
  logic [WIDTH-1:0] dabs;
  logic             neg_q;
  logic             neg_r;

  logic             n_neg;
  logic             d_neg;
  logic [WIDTH-1:0] n_abs;
  logic [WIDTH-1:0] d_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             ge;

  always_comb begin
    n_neg  = is_signed & numer[WIDTH-1];
    d_neg  = is_signed & denom[WIDTH-1];
    n_abs  = n_neg ? -numer : numer;
    d_abs  = d_neg ? -denom : denom;
    // one extra bit so the trial subtraction can never overflow
    rem_sh = {acc_rem, acc_quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dabs};
    ge     = (rem_sh >= {1'b0, dabs});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      count     <= '0;
      acc_rem   <= '0;
      acc_quo   <= '0;
      dabs      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count   <= '0;
            neg_q   <= n_neg ^ d_neg;
            neg_r   <= n_neg;
            dabs    <= d_abs;
            acc_rem <= '0;
            acc_quo <= n_abs;
            if (denom == '0) begin
              quotient  <= '1;
              remainder <= numer;
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        BUSY: begin
          acc_rem <= ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          acc_quo <= {acc_quo[WIDTH-2:0], ge};
          count   <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          quotient  <= neg_q ? -acc_quo : acc_quo;
          remainder <= neg_r ? -acc_rem : acc_rem;
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_divider_ctrl.sv
// Self-checking bench for cpu_divider_ctrl: scoreboard of expected results
// from a behavioural division model, with latency and busy/done checks.
module tb_cpu_divider_ctrl;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] numer = '0;
  logic [W-1:0] denom = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  cpu_divider_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .numer(numer), .denom(denom), .abort(abort), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
    res_t   e;
    longint a;
    longint b;
    if (d == '0) begin
      e.q = '1;
      e.r = n;
    end else if (!s) begin
      e.q = n / d;
      e.r = n % d;
    end else begin
      a   = longint'($signed(n));
      b   = longint'($signed(d));
      e.q = W'(a / b);
      e.r = W'(a % b);
    end
    return e;
  endfunction

  // Called at a negedge; drives start, tracks busy every cycle until done.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic s, input bit poke);
    int   lat;
    int   exp_lat;
    bit   seen;
    logic exp_busy;
    res_t e;
    exp_lat   = (d == '0) ? 1 : W + 2;
    numer     = n;
    denom     = d;
    is_signed = s;
    start     = 1'b1;
    sb.push_back(model(n, d, s));
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (poke && k == 5) begin
        start = 1'b1;
        numer = ~n;
        denom = 32'd3;
      end
      exp_busy = (d != '0) && (k <= W + 1);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy n=%h d=%h cycle %0d got %b exp %b", n, d, k, busy, exp_busy);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen || lat != exp_lat) begin
      errors++;
      $display("FAIL latency n=%h d=%h got %0d exp %0d (seen=%0b)", n, d, lat, exp_lat, seen);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q) begin
      errors++;
      $display("FAIL quotient n=%h d=%h s=%b got %h exp %h", n, d, s, quotient, e.q);
    end
    checks++;
    if (remainder !== e.r) begin
      errors++;
      $display("FAIL remainder n=%h d=%h s=%b got %h exp %h", n, d, s, remainder, e.r);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({busy, done} !== 2'b00 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b q=%h r=%h exp 0 0 0 0", busy, done, quotient, remainder);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_divu();
    do_op(32'd100, 32'd7, 1'b0, 1'b0);
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++;
      $display("FAIL divu_const got %0d r %0d exp 14 r 2", quotient, remainder);
    end
    @(negedge clock);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
  endtask

  task automatic test_divs();
    @(negedge clock);
    do_op(-32'sd100, 32'd7, 1'b1, 1'b0);
    checks++;
    if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL divs_const got %h r %h exp fffffff2 r fffffffe", quotient, remainder);
    end
    @(negedge clock);
    do_op(32'd100, -32'sd7, 1'b1, 1'b0);
    @(negedge clock);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    checks++;
    if (quotient !== 32'h8000_0000 || remainder !== '0) begin
      errors++;
      $display("FAIL overflow got %h r %h exp 80000000 r 0", quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    @(negedge clock);
    do_op(32'h1234_5678, '0, 1'b0, 1'b0);
    @(negedge clock);
    do_op(32'h8234_5678, '0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    bit any_done;
    any_done = 1'b0;
    @(negedge clock);
    numer = 32'd1000; denom = 32'd7; is_signed = 1'b0; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) any_done = 1'b1;
      if (k == 10) abort = 1'b1;
    end
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || any_done) begin
      errors++;
      $display("FAIL abort got busy=%b done=%b any_done=%b exp 0 0 0", busy, done, any_done);
    end
    @(negedge clock);
    do_op(32'd9, 32'd3, 1'b0, 1'b0);
    // abort with start in the same cycle: abort wins, results kept
    @(negedge clock);
    start = 1'b1; abort = 1'b1; numer = 32'd50; denom = 32'd5;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd3) begin
      errors++;
      $display("FAIL abort_start got busy=%b done=%b q=%h exp 0 0 3", busy, done, quotient);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    do_op(32'd200, 32'd9, 1'b0, 1'b0);
    do_op(-32'sd77, -32'sd5, 1'b1, 1'b0);
    do_op(32'd1000, 32'd33, 1'b0, 1'b1);
    do_op('0, 32'd5, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clock);
    numer = 32'd50; denom = 32'd3; is_signed = 1'b0; start = 1'b1;
    repeat (6) begin
      @(negedge clock);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h exp 0 0 0 0", busy, done, quotient, remainder);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic         s;
    for (int i = 0; i < 10; i++) begin
      n = $urandom;
      d = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 28));
      s = 1'($urandom_range(0, 1));
      @(negedge clock);
      do_op(n, d, s, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_divs();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
